// File: rtl/keypad_scan_pkg.sv
// Shared key codes, scanner state encoding and row-priority helper for the keypad scanner.
package keypad_scan_pkg;

  localparam logic [3:0] KEY_A    = 4'd10;
  localparam logic [3:0] KEY_B    = 4'd11;
  localparam logic [3:0] KEY_C    = 4'd12;
  localparam logic [3:0] KEY_D    = 4'd13;
  localparam logic [3:0] KEY_STAR = 4'd14;
  localparam logic [3:0] KEY_HASH = 4'd15;

  typedef enum logic [1:0] {
    SCAN_ST = 2'd0,
    DEB_ST  = 2'd1,
    HELD_ST = 2'd2
  } state_t;

  // Lowest-index low row wins when several contacts share a column.
  function automatic logic [1:0] low_row(input logic [3:0] rows_n);
    if (!rows_n[0]) return 2'd0;
    if (!rows_n[1]) return 2'd1;
    if (!rows_n[2]) return 2'd2;
    return 2'd3;
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Free-running slot divider: one-cycle tick on the last cycle of every SCAN_DIV-cycle slot.
module scan_tick_gen #(
  parameter int SCAN_DIV = 50000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int W = $clog2(SCAN_DIV);
  localparam logic [W-1:0] LAST = W'(SCAN_DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/keypad_scan.sv
// 4x4 active-low keypad scanner: row sync, per-slot sampling, debounce and one strobe per press.
//   state   | meaning
//   SCAN_ST | walking columns, waiting for any low row
//   DEB_ST  | column frozen, counting matching samples of the candidate pattern
//   HELD_ST | key reported, counting all-released samples before resuming the scan
module keypad_scan
  import keypad_scan_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] key,
  output logic       pressed,
  output logic       func_pressed
);

  localparam int CW = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [CW-1:0] CNT_DONE = CW'(DEBOUNCE_CNT);
  localparam bit FAST_ACCEPT = (DEBOUNCE_CNT == 1);

  function automatic logic [3:0] key_code(input logic [1:0] col, input logic [1:0] row);
    logic [3:0] code;
    code = 4'd0;
    case ({row, col})
      4'd0:  code = 4'd1;
      4'd1:  code = 4'd2;
      4'd2:  code = 4'd3;
      4'd3:  code = KEY_A;
      4'd4:  code = 4'd4;
      4'd5:  code = 4'd5;
      4'd6:  code = 4'd6;
      4'd7:  code = KEY_B;
      4'd8:  code = 4'd7;
      4'd9:  code = 4'd8;
      4'd10: code = 4'd9;
      4'd11: code = KEY_C;
      4'd12: code = KEY_STAR;
      4'd13: code = 4'd0;
      4'd14: code = KEY_HASH;
      4'd15: code = KEY_D;
      default: code = 4'd0;
    endcase
    return code;
  endfunction

  logic          tick;
  state_t        state, state_nxt;
  logic [3:0]    row_meta, row_sync;
  logic [3:0]    cand_pat, cand_code, accept_code;
  logic [1:0]    col;
  logic [CW-1:0] cnt, rel, cnt_inc, rel_inc;
  logic          rows_idle, match, detect, accept, advance;

  scan_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  assign rows_idle = &row_sync;
  assign match     = (row_sync == cand_pat);
  assign cnt_inc   = cnt + CW'(1);
  assign rel_inc   = rel + CW'(1);
  assign col_n     = ~(4'b0001 << col);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= SCAN_ST;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      SCAN_ST: if (tick && !rows_idle) state_nxt = FAST_ACCEPT ? HELD_ST : DEB_ST;
      DEB_ST: begin
        if (tick) begin
          if (!match)                   state_nxt = SCAN_ST;
          else if (cnt_inc == CNT_DONE) state_nxt = HELD_ST;
        end
      end
      HELD_ST: if (tick && rows_idle && rel_inc == CNT_DONE) state_nxt = SCAN_ST;
      default: state_nxt = SCAN_ST;
    endcase
  end

  always_comb begin
    detect      = 1'b0;
    accept      = 1'b0;
    advance     = 1'b0;
    accept_code = cand_code;
    case (state)
      SCAN_ST: begin
        detect      = tick && !rows_idle;
        accept      = tick && !rows_idle && FAST_ACCEPT;
        advance     = tick && rows_idle;
        accept_code = key_code(col, low_row(row_sync));
      end
      DEB_ST: begin
        accept  = tick && match && (cnt_inc == CNT_DONE);
        advance = tick && !match;
      end
      HELD_ST: advance = tick && rows_idle && (rel_inc == CNT_DONE);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta     <= 4'hF;
      row_sync     <= 4'hF;
      col          <= 2'd0;
      cand_pat     <= 4'hF;
      cand_code    <= 4'd0;
      cnt          <= '0;
      rel          <= '0;
      key          <= 4'd0;
      pressed      <= 1'b0;
      func_pressed <= 1'b0;
    end else begin
      row_meta     <= row_n;
      row_sync     <= row_meta;
      pressed      <= accept && (accept_code < 4'd10);
      func_pressed <= accept && (accept_code >= 4'd10);
      if (advance) col <= col + 2'd1;
      if (accept)  key <= accept_code;
      if (detect) begin
        cand_pat  <= row_sync;
        cand_code <= accept_code;
        cnt       <= CW'(1);
      end else if (tick && state == DEB_ST && match) begin
        cnt <= cnt_inc;
      end
      // Release count restarts on any contact and is left at zero on exit.
      if (accept)
        rel <= '0;
      else if (tick && state == HELD_ST)
        rel <= (rows_idle && rel_inc != CNT_DONE) ? rel_inc : '0;
    end
  end

endmodule
